uart_receive: RTL and testbench
===============================

# uart_receive

Serial receive half of the FPGA UART. It deserializes 8N1 frames from the `uart_rx` pin into a one-entry holding register. A synchronizer and glitch filter guard the asynchronous input. The bit period equals that of the matching transmitter: `clocks_per_bit + 1` clocks per bit. It sits beside the transmitter under the UART register block, which reads characters, consumes them and clears sticky errors.

## Interface

**Parameters**
- `DIVISOR_WIDTH`, default 16: width of `clocks_per_bit`.

**Ports**
- `clk`  in  1  single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `clocks_per_bit`  in  `DIVISOR_WIDTH`  bit period minus one, in clocks. Valid range is 4 or more. Must be held constant while a frame is in progress.
- `uart_rx`  in  1  serial line, asynchronous to `clk`; idle level is 1.
- `rx_char`  out  8  last accepted character.
- `rx_char_valid`  out  1  `rx_char` holds an unread character.
- `rx_read`  in  1  consume `rx_char`; ignored when `rx_char_valid` = 0.
- `error_clear`  in  1  clear `frame_error` and `overrun`.
- `frame_error`  out  1  sticky: a stop bit was sampled as 0.
- `overrun`  out  1  sticky: a character was dropped because the holding register was full.

## Operation

**Input conditioning**
- Two-flop synchronizer feeds a 3-entry history register. All three reset to 1.
- `rx_filt` = majority of the 3-entry history. A low pulse of 1 clock is never seen on `rx_filt`.

**State machine** (states IDLE, START, DATA, STOP, WAIT_IDLE)
- A down-counter of width `DIVISOR_WIDTH` runs in every state except IDLE and WAIT_IDLE. An event fires when it reaches 0.
- IDLE
  - When `rx_filt` = 0: go to START and load the counter with `clocks_per_bit >> 1`.
- START, at counter 0:
  - `rx_filt` = 0: go to DATA, load `clocks_per_bit`, set bit_count = 0.
  - Otherwise: a false start; return to IDLE with no flag set.
- DATA, at counter 0:
  - Shift right into an 8-bit shift register (`shift <= {rx_filt, shift[7:1]}`), so data arrives LSB first.
  - Reload `clocks_per_bit` and increment bit_count (3 bits).
  - After the 8th sample, go to STOP.
- STOP, at counter 0:
  - `rx_filt` = 1: deliver the character and go to IDLE.
  - `rx_filt` = 0: set `frame_error`, discard the character and go to WAIT_IDLE.
- WAIT_IDLE
  - Go to IDLE when `rx_filt` = 1. This stops a break condition from being decoded as repeated 0x00 frames.

**Delivery**
- `rx_char_valid` = 0, or `rx_read` = 1 in the same cycle: load `rx_char` with the shift register and set `rx_char_valid` = 1.
- Otherwise: `rx_char` and `rx_char_valid` are unchanged, and `overrun` is set.

**Consume and clear**
- `rx_read` with `rx_char_valid` = 1 and no delivery in the same cycle clears `rx_char_valid` on the next edge. `rx_char` keeps its value.
- `error_clear` clears both sticky flags on the next edge. If a set and a clear land in the same cycle, the set wins.

## Timing

- Reset values:
  - `rx_char` = 0x00, `rx_char_valid` = 0, `frame_error` = 0, `overrun` = 0.
  - State = IDLE, counter = 0.
  - Synchronizer and history = 1.
- Reset asserted mid-frame aborts the frame immediately; nothing is delivered or flagged.
- Pin to `rx_filt` latency is 4 clocks for a step input.
- Sample points, with P = `clocks_per_bit + 1`:
  - Start bit: `(clocks_per_bit >> 1) + 1` clocks after the `rx_filt` falling edge.
  - Each later sample: exactly P clocks after the previous one.
- `rx_char_valid`, `overrun` and `frame_error` update on the clock edge following the stop-bit sample.
- A new start bit is accepted from the cycle after the return to IDLE. This is half a bit into the stop bit, so back-to-back frames are received without loss.
- The receiver tolerates at least ±3% baud mismatch at `clocks_per_bit` ≥ 15.

## Test plan

1. `clocks_per_bit` = 15; send 0xA5 at P = 16 → `rx_char` = 0xA5, `rx_char_valid` = 1 and no flags. Pulse `rx_read` → `rx_char_valid` = 0 next cycle.
2. On an idle line, drive a 1-clock low glitch, then a 5-clock low pulse → no state leaves IDLE beyond START, `rx_char_valid` stays 0 and no flags are set.
3. Send a frame with data 0x3C and stop bit 0 → `frame_error` = 1, `rx_char_valid` = 0. Hold the line low for 200 clocks, release, then send 0x3C → 0x3C received once. `frame_error` stays 1 until `error_clear`, then reads 0.
4. Send 0x11 then 0x22 back-to-back without reads → `rx_char` = 0x11 and `overrun` = 1. Repeat with `rx_read` pulsed exactly on the 0x22 delivery cycle → `rx_char` = 0x22 and `overrun` = 0.
5. Assert `reset_n` = 0 during the 4th data bit → all outputs return to reset values asynchronously. After release, send 0x5A → 0x5A received.
6. Set `clocks_per_bit` = 4; send 0x00, 0xFF and 0x81 back-to-back → all three received in order with no flags.

Source files
------------

// File: rtl/uart_receive.sv
// uart_receive: 8N1 serial receiver with input synchronizer, 3-tap majority
// glitch filter, one-entry holding register and sticky framing/overrun flags.
module uart_receive #(
  parameter int unsigned DIVISOR_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [DIVISOR_WIDTH-1:0] clocks_per_bit,
  input  logic                     uart_rx,
  output logic [7:0]               rx_char,
  output logic                     rx_char_valid,
  input  logic                     rx_read,
  input  logic                     error_clear,
  output logic                     frame_error,
  output logic                     overrun
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t                   state;
  logic [1:0]               sync;
  logic [2:0]               hist;
  logic                     rx_filt;
  logic [DIVISOR_WIDTH-1:0] count;
  logic [2:0]               bit_count;
  logic [7:0]               shift;
  logic                     tick_c;
  logic                     deliver_c;
  logic                     frame_set_c;
  logic                     overrun_set_c;
  logic                     accept_c;

  // Two-flop synchronizer followed by a 3-entry history for the majority filter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync <= 2'b11;
      hist <= 3'b111;
    end else begin
      sync <= {sync[0], uart_rx};
      hist <= {hist[1:0], sync[1]};
    end
  end

  assign rx_filt = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);

  assign tick_c        = (count == '0);
  assign deliver_c     = (state == STOP) && tick_c && rx_filt;
  assign frame_set_c   = (state == STOP) && tick_c && !rx_filt;
  assign accept_c      = deliver_c && (!rx_char_valid || rx_read);
  assign overrun_set_c = deliver_c && !accept_c;

  // Frame sequencer: bit timing counter, sampling and deserialization
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      count     <= '0;
      bit_count <= '0;
      shift     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_filt) begin
            state <= START;
            count <= clocks_per_bit >> 1;
          end
        end
        START: begin
          if (tick_c) begin
            if (!rx_filt) begin
              state     <= DATA;
              count     <= clocks_per_bit;
              bit_count <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            count <= count - DIVISOR_WIDTH'(1);
          end
        end
        DATA: begin
          if (tick_c) begin
            shift     <= {rx_filt, shift[7:1]};
            count     <= clocks_per_bit;
            bit_count <= bit_count + 3'd1;
            if (bit_count == 3'd7) begin
              state <= STOP;
            end
          end else begin
            count <= count - DIVISOR_WIDTH'(1);
          end
        end
        STOP: begin
          if (tick_c) begin
            state <= rx_filt ? IDLE : WAIT_IDLE;
          end else begin
            count <= count - DIVISOR_WIDTH'(1);
          end
        end
        WAIT_IDLE: begin
          // A held-low line (break) must return high before a new start is seen
          if (rx_filt) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Holding register: delivery takes priority over a same-cycle read
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_char       <= 8'h00;
      rx_char_valid <= 1'b0;
    end else if (accept_c) begin
      rx_char       <= shift;
      rx_char_valid <= 1'b1;
    end else if (rx_read && rx_char_valid) begin
      rx_char_valid <= 1'b0;
    end
  end

  // Sticky error flags; a set in the same cycle as a clear wins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (frame_set_c) begin
        frame_error <= 1'b1;
      end else if (error_clear) begin
        frame_error <= 1'b0;
      end
      if (overrun_set_c) begin
        overrun <= 1'b1;
      end else if (error_clear) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_receive.sv
// Directed bench for uart_receive with a scoreboard of expected characters.
module tb_uart_receive;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] cpb;
  logic        uart_rx;
  logic [7:0]  rx_char;
  logic        rx_char_valid;
  logic        rx_read;
  logic        error_clear;
  logic        frame_error;
  logic        overrun;

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] sb[$];

  uart_receive #(.DIVISOR_WIDTH(16)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .clocks_per_bit(cpb),
    .uart_rx(uart_rx),
    .rx_char(rx_char),
    .rx_char_valid(rx_char_valid),
    .rx_read(rx_read),
    .error_clear(error_clear),
    .frame_error(frame_error),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one frame on the pin at P = cpb+1 clocks per bit. Optionally pulse
  // rx_read on the stop-sample cycle, or assert reset mid-bit and return.
  task automatic send(input logic [7:0] d, input logic stop, input bit pulse, input int rst_bit);
    logic [9:0] fr;
    int p;
    int h;
    fr = {stop, d, 1'b0};
    p  = int'(cpb) + 1;
    h  = int'(cpb >> 1);
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < p; c++) begin
        @(negedge clk);
        if (b == rst_bit && c == p / 2) begin
          reset_n = 1'b0;
          return;
        end
        uart_rx = fr[b];
        if (pulse) rx_read = (b == 9 && c == 5 + h);
      end
    end
  endtask

  // Wait for a character, compare against the scoreboard head, optionally consume it
  task automatic expect_char(input string tag, input bit do_read);
    int n;
    logic [7:0] exp;
    n = 0;
    while (rx_char_valid !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(rx_char_valid), 32'd1);
    if (rx_char_valid === 1'b1) begin
      exp = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
      check({tag, "_char"}, 32'(rx_char), 32'(exp));
      if (do_read) begin
        rx_read = 1'b1;
        @(negedge clk);
        rx_read = 1'b0;
        check({tag, "_consumed"}, 32'(rx_char_valid), 32'd0);
      end
    end
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    error_clear = 1'b1;
    @(negedge clk);
    error_clear = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; uart_rx = 1'b1; rx_read = 1'b0; error_clear = 1'b0; cpb = 16'd15;
    repeat (3) @(negedge clk);
    check("rst_char", 32'(rx_char), 32'h00);
    check("rst_valid", 32'(rx_char_valid), 32'd0);
    check("rst_ferr", 32'(frame_error), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);

    // Basic frame
    sb.push_back(8'hA5);
    send(8'hA5, 1'b1, 1'b0, -1);
    check("t1_ferr", 32'(frame_error), 32'd0);
    check("t1_ovr", 32'(overrun), 32'd0);
    expect_char("t1", 1'b1);

    // Glitches on an idle line
    repeat (10) @(negedge clk);
    uart_rx = 1'b0; @(negedge clk); uart_rx = 1'b1;
    repeat (20) @(negedge clk);
    uart_rx = 1'b0; repeat (5) @(negedge clk); uart_rx = 1'b1;
    repeat (60) @(negedge clk);
    check("t2_valid", 32'(rx_char_valid), 32'd0);
    check("t2_ferr", 32'(frame_error), 32'd0);
    check("t2_ovr", 32'(overrun), 32'd0);
    sb.push_back(8'hC3);
    send(8'hC3, 1'b1, 1'b0, -1);
    expect_char("t2_after", 1'b1);

    // Framing error, break, then recovery
    repeat (10) @(negedge clk);
    send(8'h3C, 1'b0, 1'b0, -1);
    check("t3_ferr_set", 32'(frame_error), 32'd1);
    check("t3_no_valid", 32'(rx_char_valid), 32'd0);
    uart_rx = 1'b0;
    repeat (200) @(negedge clk);
    uart_rx = 1'b1;
    repeat (20) @(negedge clk);
    check("t3_break_nochar", 32'(rx_char_valid), 32'd0);
    sb.push_back(8'h3C);
    send(8'h3C, 1'b1, 1'b0, -1);
    expect_char("t3", 1'b1);
    repeat (200) @(negedge clk);
    check("t3_once", 32'(rx_char_valid), 32'd0);
    check("t3_ferr_sticky", 32'(frame_error), 32'd1);
    pulse_clear();
    check("t3_ferr_clr", 32'(frame_error), 32'd0);

    // Overrun on back-to-back frames without reads
    repeat (10) @(negedge clk);
    sb.push_back(8'h11);
    send(8'h11, 1'b1, 1'b0, -1);
    send(8'h22, 1'b1, 1'b0, -1);
    check("t4a_ovr", 32'(overrun), 32'd1);
    expect_char("t4a", 1'b1);
    pulse_clear();
    check("t4a_ovr_clr", 32'(overrun), 32'd0);

    // Read coinciding with delivery: no overrun
    repeat (10) @(negedge clk);
    sb.push_back(8'h22);
    send(8'h11, 1'b1, 1'b0, -1);
    send(8'h22, 1'b1, 1'b1, -1);
    check("t4b_ovr", 32'(overrun), 32'd0);
    expect_char("t4b", 1'b0);

    // Asynchronous reset during the 4th data bit
    repeat (10) @(negedge clk);
    send(8'h5A, 1'b1, 1'b0, 4);
    #1;
    check("t5_char", 32'(rx_char), 32'h00);
    check("t5_valid", 32'(rx_char_valid), 32'd0);
    check("t5_ferr", 32'(frame_error), 32'd0);
    check("t5_ovr", 32'(overrun), 32'd0);
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    sb.push_back(8'h5A);
    send(8'h5A, 1'b1, 1'b0, -1);
    expect_char("t5", 1'b1);

    // Minimum divisor, back-to-back frames
    repeat (10) @(negedge clk);
    cpb = 16'd4;
    repeat (10) @(negedge clk);
    sb.push_back(8'h00);
    sb.push_back(8'hFF);
    sb.push_back(8'h81);
    fork
      begin
        send(8'h00, 1'b1, 1'b0, -1);
        send(8'hFF, 1'b1, 1'b0, -1);
        send(8'h81, 1'b1, 1'b0, -1);
      end
      begin
        expect_char("t6_0", 1'b1);
        expect_char("t6_1", 1'b1);
        expect_char("t6_2", 1'b1);
      end
    join
    check("t6_ferr", 32'(frame_error), 32'd0);
    check("t6_ovr", 32'(overrun), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
